load_queue: RTL
===============

LOAD_QUEUE -- requirements
Module: load_queue

Interface
REQ-001 Parameter DATA_W, default 32, operand width in bits.
REQ-002 Parameter REG_AW, default 4, destination register index width.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  load request present.
REQ-007 in_ready  output  1  queue can accept a request this cycle.
REQ-008 in_dest  input  REG_AW  destination register index.
REQ-009 in_operand  input  DATA_W  operand to load.
REQ-010 flush  input  1  synchronous discard of all queued loads.
REQ-011 wb_valid  output  1  head entry presented for register-file writeback.
REQ-012 wb_ready  input  1  register file accepts head entry.
REQ-013 wb_dest  output  REG_AW  head entry destination.
REQ-014 wb_data  output  DATA_W  head entry operand.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-016 rd_query  input  REG_AW  register index checked for pending load.
REQ-017 rd_pending  output  1  some queued entry targets rd_query.

Function
REQ-018 Push SHALL occur on a rising edge with in_valid && in_ready && !flush; entry {in_dest, in_operand} written at tail, tail advances.
REQ-019 Pop SHALL occur on a rising edge with wb_valid && wb_ready && !flush; head advances.
REQ-020 in_ready SHALL equal (count < DEPTH), independent of wb_ready; no pass-through when full.
REQ-021 wb_valid SHALL equal (count != 0); wb_dest/wb_data SHALL show the head entry, and all-zero when empty.
REQ-022 Latency: an entry pushed into an empty queue SHALL appear with wb_valid high exactly one cycle later.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and be legal at any occupancy 1..DEPTH-1, and at DEPTH only as pop (in_ready low).
REQ-024 Head/tail pointers SHALL wrap modulo DEPTH; order is strictly FIFO.
REQ-025 flush SHALL have priority: next cycle count=0, pointers=0, wb_valid=0; push and pop in the flush cycle are discarded.
REQ-026 rd_pending SHALL be combinational: OR over occupied entries of (dest == rd_query); 0 when empty.
REQ-027 Requests with in_valid low or in_ready low SHALL leave state unchanged.

Reset
REQ-028 nrst low SHALL immediately clear count, head, tail to 0; wb_valid, wb_dest, wb_data, rd_pending read 0.
REQ-029 Storage array need not be reset; occupancy gating guarantees no stale data is visible.
REQ-030 in_valid while nrst low SHALL be ignored; first push possible on first rising edge after nrst deasserts.

Configuration
REQ-031 Macro LOAD_CLASSIFY_EN defined: outputs wb_is_zero, wb_is_inf, wb_is_nan (1 bit each) SHALL classify wb_data as IEEE-754 binary32, combinationally, all 0 when empty; elaboration SHALL fail if DATA_W != 32.
REQ-032 Macro undefined: those three ports and the classifier SHALL be absent; all other behaviour identical.

Structure
REQ-033 Package load_pkg SHALL hold default DATA_W/REG_AW constants, typedef load_entry_t {dest, operand}, and the binary32 exponent/mantissa field constants.
REQ-034 Classifier SHALL be sub-module fp_classify, instantiated only under LOAD_CLASSIFY_EN; queue storage stays inline.

Verification
REQ-035 Reset then push {dest=3, 0x3F800000} with wb_ready=0 -> next cycle wb_valid=1, wb_dest=3, wb_data=0x3F800000, count=1, rd_pending=1 for rd_query=3, 0 for 4.
REQ-036 Push 4 entries (dest 1..4), wb_ready=0 -> count=4, in_ready=0; fifth push ignored; then wb_ready=1 drains dests 1,2,3,4 in order.
REQ-037 count=2 with push and pop same cycle, repeated 10 cycles -> count stays 2, pointers wrap, data order preserved.
REQ-038 count=3, assert flush with in_valid=1 and wb_ready=1 -> next cycle count=0, wb_valid=0, wb_data=0, no entry retained.
REQ-039 nrst pulsed low mid-drain at count=2 -> outputs zero asynchronously, count=0 after release, subsequent push works normally.
REQ-040 With LOAD_CLASSIFY_EN: heads 0x00000000, 0x7F800000, 0x7FC00000 -> wb_is_zero, wb_is_inf, wb_is_nan respectively high, others low.

Source files
------------

// File: rtl/load_pkg.sv
// Shared constants and types for the load queue and its optional binary32 classifier.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package load_pkg;

    // Default widths used as parameter defaults by load_queue.
    localparam int LOAD_DATA_W = 32;
    localparam int LOAD_REG_AW = 4;

    // One queued load at the default widths: destination register and operand.
    typedef struct packed {
        logic [LOAD_REG_AW-1:0] dest;
        logic [LOAD_DATA_W-1:0] operand;
    } load_entry_t;

    // IEEE-754 binary32 field positions.
    localparam int          FP32_EXP_MSB  = 30;
    localparam int          FP32_EXP_LSB  = 23;
    localparam int          FP32_MANT_MSB = 22;
    localparam logic [7:0]  FP32_EXP_ALL1 = 8'hFF;

endpackage

// File: rtl/fp_classify.sv
// Classifies a binary32 value as zero, infinity or NaN; every flag is forced low when valid_i is low.
// Latency: combinational, no clock.
// Backpressure: none; it follows its inputs.
// Ports:
//   valid_i                          - the value is live; when low, all flags read 0
//   bits_i[30:0]                     - exponent and mantissa (sign does not affect the class)
//   is_zero_o / is_inf_o / is_nan_o  - class flags
module fp_classify
    import load_pkg::*;
(
    input  logic        valid_i,
    input  logic [30:0] bits_i,
    output logic        is_zero_o,
    output logic        is_inf_o,
    output logic        is_nan_o
);

    logic [7:0]  exp_fld;
    logic [22:0] mant_fld;

    assign exp_fld  = bits_i[FP32_EXP_MSB:FP32_EXP_LSB];
    assign mant_fld = bits_i[FP32_MANT_MSB:0];

    assign is_zero_o = valid_i && (exp_fld == 8'h00) && (mant_fld == '0);
    assign is_inf_o  = valid_i && (exp_fld == FP32_EXP_ALL1) && (mant_fld == '0);
    assign is_nan_o  = valid_i && (exp_fld == FP32_EXP_ALL1) && (mant_fld != '0);

endmodule

// File: rtl/load_queue.sv
// In-order load queue: buffers {dest, operand} and presents its head for register-file writeback.
// Latency: a push into an empty queue is visible on wb_* one cycle later; rd_pending is combinational.
// Backpressure: in_ready drops at full (no pass-through); the head holds while wb_ready is low; flush wins.
// Ports:
//   clk, nrst                                 - clock; asynchronous active-low reset
//   in_valid/in_ready/in_dest/in_operand      - request side
//   flush                                     - synchronous discard of every queued entry
//   wb_valid/wb_ready/wb_dest/wb_data         - head entry for writeback; all zero when empty
//   count                                     - occupancy, 0..DEPTH
//   rd_query/rd_pending                       - does any queued entry target rd_query
//   wb_is_zero/wb_is_inf/wb_is_nan            - binary32 class of wb_data, only when LOAD_CLASSIFY_EN is defined
module load_queue
    import load_pkg::*;
#(
    parameter int DATA_W = LOAD_DATA_W,
    parameter int REG_AW = LOAD_REG_AW,
    parameter int DEPTH  = 4
)(
    input  logic                       clk,
    input  logic                       nrst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [REG_AW-1:0]          in_dest,
    input  logic [DATA_W-1:0]          in_operand,
    input  logic                       flush,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [REG_AW-1:0]          wb_dest,
    output logic [DATA_W-1:0]          wb_data,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [REG_AW-1:0]          rd_query,
    output logic                       rd_pending
`ifdef LOAD_CLASSIFY_EN
    ,
    output logic                       wb_is_zero,
    output logic                       wb_is_inf,
    output logic                       wb_is_nan
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("load_queue: DEPTH must be a power of two and at least 2");
    end

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic [DATA_W-1:0] operand;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    logic [DEPTH-1:0] occ, hit;

    assign in_ready = (count_q < CW'(DEPTH));
    assign wb_valid = (count_q != '0);
    assign push     = in_valid && in_ready && !flush;
    assign pop      = wb_valid && wb_ready && !flush;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset: every read path below is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{dest: in_dest, operand: in_operand};
        end
    end

    assign count   = count_q;
    assign wb_dest = wb_valid ? mem_q[head_q].dest    : '0;
    assign wb_data = wb_valid ? mem_q[head_q].operand : '0;

    // Slot i is occupied when its distance from head (mod DEPTH) is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign occ[i] = ({1'b0, PW'(i) - head_q} < count_q);
        assign hit[i] = occ[i] && (mem_q[i].dest == rd_query);
    end
    assign rd_pending = |hit;

`ifdef LOAD_CLASSIFY_EN
    if (DATA_W != 32) begin : g_bad_width
        $error("load_queue: LOAD_CLASSIFY_EN requires DATA_W == 32");
    end

    fp_classify u_fp_classify (
        .valid_i   (wb_valid),
        .bits_i    (wb_data[30:0]),
        .is_zero_o (wb_is_zero),
        .is_inf_o  (wb_is_inf),
        .is_nan_o  (wb_is_nan)
    );
`endif

endmodule
